// File: rtl/pace_timing_core.sv
// -----------------------------------------------------------------------------
// pace_timing_core
//
// Demand-mode (VVI) ventricular pacing timer. The raw heartbeat comparator
// input is synchronised and edge-detected. A sensed beat in the alert window
// inhibits pacing. If the escape interval expires first, a fixed-width pacing
// pulse is issued. Every accepted sense or pace is followed by a refractory
// window. The magnet input forces asynchronous fixed-rate pacing.
//
// Parameters
//   CNT_W    width of the interval and phase counters
//   LRI      lower-rate (escape) interval in clk cycles
//   PULSE_W  pacing pulse width in clk cycles
//   REFRACT  refractory length in clk cycles
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          pacing enable; low forces IDLE on the next edge
//   magnet      fixed-rate request; when high, sensing is ignored
//   sense_raw   heartbeat comparator output, asynchronous to clk
//   pace_out    pacing pulse, high exactly while in PACE
//   sense_evt   one-cycle strobe per accepted sensed beat
//   refractory  high while in PACE or REFRACT
//   state       IDLE=0, ALERT=1, PACE=2, REFRACT=3
//   pace_cnt    delivered-pace count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module pace_timing_core #(
    parameter int CNT_W   = 16,
    parameter int LRI     = 1000,
    parameter int PULSE_W = 2,
    parameter int REFRACT = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       magnet,
    input  logic       sense_raw,
    output logic       pace_out,
    output logic       sense_evt,
    output logic       refractory,
    output logic [1:0] state,
    output logic [7:0] pace_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALERT   = 2'd1,
        ST_PACE    = 2'd2,
        ST_REFRACT = 2'd3
    } state_t;

    // Terminal counts, expressed at counter width so comparisons are exact.
    localparam logic [CNT_W-1:0] IC_LAST    = CNT_W'(LRI - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] REFR_LAST  = CNT_W'(REFRACT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Input synchroniser plus history flop for rising-edge detection
    // -------------------------------------------------------------------------
    logic sync1, sync2, hist;
    logic rise;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= sense_raw;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;

    // -------------------------------------------------------------------------
    // FSM with interval counter (ic) and phase counter (ph)
    // -------------------------------------------------------------------------
    state_t            st_q, st_d;
    logic [CNT_W-1:0]  ic_q, ic_d;
    logic [CNT_W-1:0]  ph_q, ph_d;
    logic [7:0]        pace_cnt_d;
    logic              sense_evt_d;
    logic              accept;

    // Edges outside ALERT, or while the magnet is applied, are simply dropped.
    assign accept = rise & (st_q == ST_ALERT) & ~magnet;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        st_d        = st_q;
        ic_d        = ic_q;
        ph_d        = ph_q;
        pace_cnt_d  = pace_cnt;
        sense_evt_d = 1'b0;

        if (!en) begin
            st_d = ST_IDLE;
            ic_d = '0;
            ph_d = '0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    st_d = ST_ALERT;
                    ic_d = '0;
                    ph_d = '0;
                end
                ST_ALERT: begin
                    // A sense on the same cycle as escape expiry wins.
                    if (accept) begin
                        st_d        = ST_REFRACT;
                        ic_d        = '0;
                        ph_d        = '0;
                        sense_evt_d = 1'b1;
                    end else if (ic_q == IC_LAST) begin
                        st_d       = ST_PACE;
                        ic_d       = '0;
                        ph_d       = '0;
                        pace_cnt_d = pace_cnt + 8'd1;
                    end else begin
                        ic_d = ic_q + CNT_ONE;
                    end
                end
                ST_PACE: begin
                    // ic keeps running so the next escape is timed from pace start.
                    ic_d = ic_q + CNT_ONE;
                    if (ph_q == PULSE_LAST) begin
                        st_d = ST_REFRACT;
                        ph_d = '0;
                    end else begin
                        ph_d = ph_q + CNT_ONE;
                    end
                end
                ST_REFRACT: begin
                    ic_d = ic_q + CNT_ONE;
                    if (ph_q == REFR_LAST) begin
                        st_d = ST_ALERT;
                        ph_d = '0;
                    end else begin
                        ph_d = ph_q + CNT_ONE;
                    end
                end
                default: begin
                    st_d = ST_IDLE;
                    ic_d = '0;
                    ph_d = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode, so they change on
    // the same edge as the state and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            ic_q       <= '0;
            ph_q       <= '0;
            pace_cnt   <= 8'd0;
            sense_evt  <= 1'b0;
            pace_out   <= 1'b0;
            refractory <= 1'b0;
        end else begin
            st_q       <= st_d;
            ic_q       <= ic_d;
            ph_q       <= ph_d;
            pace_cnt   <= pace_cnt_d;
            sense_evt  <= sense_evt_d;
            pace_out   <= (st_d == ST_PACE);
            refractory <= (st_d == ST_PACE) || (st_d == ST_REFRACT);
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_pace_timing_core.sv
// -----------------------------------------------------------------------------
// tb_pace_timing_core
//
// Directed bench for pace_timing_core with LRI=20, PULSE_W=2, REFRACT=5,
// CNT_W=8. Outputs are sampled 1 time unit after each rising clock edge;
// the bench keeps its own cycle count and timestamps pace rises and sense
// strobes so interval checks are made against hand-derived cycle numbers.
// -----------------------------------------------------------------------------
module tb_pace_timing_core;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       magnet;
    logic       sense_raw;
    logic       pace_out;
    logic       sense_evt;
    logic       refractory;
    logic [1:0] state;
    logic [7:0] pace_cnt;

    pace_timing_core #(
        .CNT_W  (8),
        .LRI    (20),
        .PULSE_W(2),
        .REFRACT(5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .magnet    (magnet),
        .sense_raw (sense_raw),
        .pace_out  (pace_out),
        .sense_evt (sense_evt),
        .refractory(refractory),
        .state     (state),
        .pace_cnt  (pace_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int errors      = 0;
    int cyc         = 0;
    int pace_rises  = 0;
    int last_pace_at = 0;
    int prev_pace_at = 0;
    int sevt_cnt    = 0;
    bit pace_q      = 1'b0;
    int exp_evt_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pace_out && !pace_q) begin
            prev_pace_at = last_pace_at;
            last_pace_at = cyc;
            pace_rises++;
        end
        pace_q = pace_out;
        if (sense_evt) sevt_cnt++;
    endtask

    // Tick until a new pace rise is seen, bounded to 100 cycles.
    task automatic wait_pace();
        int r0;
        int n;
        r0 = pace_rises;
        n  = 0;
        while (pace_rises == r0 && n < 100) begin
            tick();
            n++;
        end
        check("pace_arrived", pace_rises - r0, 1);
    endtask

    // Drive 2-cycle sense pulses every per cycles starting off cycles after
    // base; each strobe must appear 3 edges after the pulse is first driven.
    task automatic run_sense(input int base, input int off, input int per, input int n);
        int   rel;
        logic v;
        int   e;
        for (int i = 0; i < n; i++) begin
            rel = cyc - base;
            v   = (rel >= off) && (((rel - off) % per) < 2);
            if (v && !sense_raw) exp_evt_q.push_back(cyc + 3);
            sense_raw = v;
            tick();
            if (sense_evt) begin
                e = (exp_evt_q.size() > 0) ? exp_evt_q.pop_front() : -1;
                check("sense_latency", cyc, e);
            end
        end
        sense_raw = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int alert_at;
        int p;
        int s0;
        int r0;
        int c0;
        int e;

        // ---- reset state ----
        rst_n = 1'b0; en = 1'b0; magnet = 1'b0; sense_raw = 1'b0;
        tick(); tick();
        check("rst_state",      state,      0);
        check("rst_pace_out",   pace_out,   0);
        check("rst_sense_evt",  sense_evt,  0);
        check("rst_refractory", refractory, 0);
        check("rst_pace_cnt",   pace_cnt,   0);

        // ---- 1: free-running pacing ----
        en = 1'b1; rst_n = 1'b1;
        tick();
        check("alert_after_release", state, 1);
        alert_at = cyc;
        wait_pace();
        check("first_pace_delay", last_pace_at - alert_at, 20);
        check("pace_state",       state,    2);
        check("pace_cnt_1",       pace_cnt, 1);
        check("refr_at_pace",     refractory, 1);
        p = last_pace_at;
        tick();
        check("pulse_cycle2",     pace_out, 1);
        tick();
        check("pulse_end",        pace_out, 0);
        check("refract_state",    state,    3);
        repeat (4) tick();
        check("refr_cycle7",      refractory, 1);
        tick();
        check("refr_end",         refractory, 0);
        check("alert_after_refr", state,      1);
        check("refr_end_cycle",   cyc - p,    7);
        wait_pace();
        check("pace_gap_2",       last_pace_at - prev_pace_at, 20);
        wait_pace();
        check("pace_gap_3",       last_pace_at - prev_pace_at, 20);
        check("pace_cnt_3",       pace_cnt, 3);
        check("no_sense_t1",      sevt_cnt, 0);

        // ---- async reset while pace_out is high ----
        check("pulse_before_rst", pace_out, 1);
        rst_n = 1'b0;
        #1;
        check("async_clear_pulse", pace_out, 0);
        check("async_clear_cnt",   pace_cnt, 0);
        rst_n = 1'b1;

        // ---- 2: sensed rhythm inhibits pacing ----
        tick();
        check("alert_t2", state, 1);
        alert_at = cyc;
        s0 = sevt_cnt;
        r0 = pace_rises;
        run_sense(alert_at, 4, 15, 70);
        check("sense_count_t2", sevt_cnt - s0,   5);
        check("no_pace_t2",     pace_rises - r0, 0);
        check("pace_cnt_t2",    pace_cnt,        0);

        // ---- 3: sense during PACE/REFRACT is discarded ----
        wait_pace();
        check("pace_after_sense", last_pace_at - (alert_at + 67), 20);
        s0 = sevt_cnt;
        sense_raw = 1'b1;
        tick(); tick();
        check("refr_at_rise", state, 3);
        sense_raw = 1'b0;
        wait_pace();
        check("pace_gap_t3",    last_pace_at - prev_pace_at, 20);
        check("no_sense_t3",    sevt_cnt - s0, 0);

        // ---- 4: sense coincides with ic == LRI-1 ----
        c0 = pace_cnt;
        repeat (17) tick();
        sense_raw = 1'b1;
        tick(); tick();
        sense_raw = 1'b0;
        tick();
        check("tie_sense_evt", sense_evt, 1);
        check("tie_no_pace",   pace_out,  0);
        check("tie_state",     state,     3);
        check("tie_pace_cnt",  pace_cnt,  c0);
        e = cyc;
        wait_pace();
        check("pace_after_tie", last_pace_at - e, 20);

        // ---- 5: magnet forces fixed rate ----
        magnet = 1'b1;
        s0 = sevt_cnt;
        r0 = pace_rises;
        for (int i = 0; i < 60; i++) begin
            if (i % 6 == 0) sense_raw = ~sense_raw;
            tick();
        end
        check("magnet_paces",     pace_rises - r0, 3);
        check("magnet_gap",       last_pace_at - prev_pace_at, 20);
        check("magnet_no_sense",  sevt_cnt - s0, 0);
        magnet = 1'b0;
        sense_raw = 1'b0;

        // ---- 6: en drop mid-pulse, reset mid-REFRACT ----
        check("pulse_before_en", pace_out, 1);
        en = 1'b0;
        tick();
        check("en_drop_pulse", pace_out, 0);
        check("en_drop_idle",  state,    0);
        tick();
        check("idle_held",     state,    0);
        en = 1'b1;
        tick();
        check("alert_reenable", state, 1);
        alert_at = cyc;
        wait_pace();
        check("pace_after_reenable", last_pace_at - alert_at, 20);
        repeat (3) tick();
        check("mid_refract", state, 3);
        rst_n = 1'b0;
        #1;
        check("rst6_state",      state,      0);
        check("rst6_pace_out",   pace_out,   0);
        check("rst6_sense_evt",  sense_evt,  0);
        check("rst6_refractory", refractory, 0);
        check("rst6_pace_cnt",   pace_cnt,   0);
        #1;
        rst_n = 1'b1;
        tick();
        check("alert_after_rst6", state, 1);
        alert_at = cyc;
        wait_pace();
        check("first_pace_rst6", last_pace_at - alert_at, 20);
        check("pace_cnt_rst6",   pace_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pace_timing_core.md
# pace_timing_core

Demand-mode (VVI) ventricular pacing timer at the core of the pacemaker user logic, directly behind the top-level pin wrapper. It synchronises the raw heartbeat comparator input and detects its rising edges. A sensed beat inhibits pacing. If no beat is sensed within the escape interval, it issues a fixed-width pacing pulse. Each sensed beat or pace is followed by a refractory window. A magnet input forces asynchronous fixed-rate pacing.

## Interface

Parameters:
- CNT_W, 16, width of the interval counter
- LRI, 1000, lower-rate interval in clk cycles (60 bpm at 1 kHz)
- PULSE_W, 2, pacing pulse width in clk cycles
- REFRACT, 300, refractory length in clk cycles
- Legal ranges: PULSE_W ≥ 1, REFRACT ≥ 1, PULSE_W+REFRACT+1 < LRI < 2^CNT_W

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  pacing enable, synchronous
- magnet  in  1  asynchronous-mode request, synchronous; when high, sensing is ignored
- sense_raw  in  1  heartbeat comparator output, asynchronous to clk
- pace_out  out  1  pacing pulse
- sense_evt  out  1  one-cycle strobe on each accepted sensed beat
- refractory  out  1  high in PACE or REFRACT
- state  out  2  IDLE=0, ALERT=1, PACE=2, REFRACT=3
- pace_cnt  out  8  count of delivered paces, wraps 255→0

## Operation

- sense_raw passes through a 2-flop synchroniser followed by a 3rd history flop.
- rise = sync2 & ~hist.
- Sense is "accepted" when all of: rise, state==ALERT, magnet==0.
- ic is the interval counter (CNT_W bits):
  - Cleared to 0 on every accepted sense and on every pace start.
  - Otherwise increments each cycle while not IDLE.
  - Never wraps under legal parameters.
- FSM:
  - IDLE: en=1 → ALERT, with ic=0.
  - ALERT: accepted sense → REFRACT, with ic=0 and sense_evt=1. Otherwise, if ic==LRI-1 → PACE, with ic=0 and pace_cnt+1.
  - PACE: stays for PULSE_W cycles, then → REFRACT.
  - REFRACT: stays for REFRACT cycles, then → ALERT.
  - Any state: en=0 → IDLE next edge. In IDLE, ic is held at 0 and pace_out=0.
- A separate phase counter times PACE and REFRACT. ic keeps running through both.
- pace_out=1 exactly while state==PACE. All outputs are registered.
- Rising edges of sense_raw in PACE, REFRACT or IDLE are discarded, not queued.

## Timing

- Reset (rst_n low, asynchronous): state=IDLE, pace_out=0, sense_evt=0, refractory=0, pace_cnt=0, ic=0, synchroniser flops=0.
- Release of reset is followed by normal edge sampling. With en=1, state=ALERT after the first edge.
- Sense latency: sense_raw rises before edge k → rise is true after edge k+1 → sense_evt=1 and state=REFRACT after edge k+2 (3 edges).
- Pace timing:
  - With no sensing, consecutive pace_out rising edges are exactly LRI cycles apart.
  - The first pace occurs LRI cycles after entering ALERT from IDLE.
  - After a sense accepted at edge e, the next pace starts at edge e+LRI.
- pace_out stays high for exactly PULSE_W cycles. refractory stays high for PULSE_W+REFRACT cycles after a pace, and for REFRACT cycles after a sense.
- Simultaneous accepted sense and ic==LRI-1: sense wins. No pace is issued, and pace_cnt is unchanged.
- en dropping mid-PACE truncates the pulse: pace_out=0 on the next edge.
- rst_n asserted mid-pulse clears pace_out immediately, asynchronously.
- magnet: sensing is ignored, giving fixed rate 1/LRI. magnet changing mid-interval does not clear ic.

## Test plan

Bench parameters: LRI=20, PULSE_W=2, REFRACT=5, CNT_W=8.

1. No sense, en=1 from reset release:
   - pace_out is high for 2 cycles, starting every 20 cycles.
   - pace_cnt is 3 after the third pulse.
   - refractory is high for 7 cycles per pace.
2. sense_raw pulses every 15 cycles, with the first at 5 cycles after ALERT:
   - sense_evt fires 3 edges after each rise.
   - pace_out never asserts, and pace_cnt stays 0.
3. Sense rise lands 2 cycles after a pace start (in PACE/REFRACT):
   - No sense_evt.
   - The next pace occurs exactly 20 cycles after the previous pace.
4. Sense timed so acceptance coincides with ic==19:
   - sense_evt=1, no pace.
   - The next pace occurs 20 cycles later.
5. magnet=1 with sense_raw toggling every 6 cycles:
   - Paces every 20 cycles, and sense_evt stays 0.
6. en=0 mid-pulse, then rst_n pulsed low mid-REFRACT:
   - pace_out drops on the next edge.
   - After reset, all outputs are 0, and state goes IDLE then ALERT.
   - The first pace occurs 20 cycles after ALERT entry.
